psum_tx: RTL and testbench
==========================

# psum_tx

Transmit side of the MAC-array-to-psum-accumulator link. Accepts raw 64-bit MAC results from the MAC array core and tags each beat with the 32-bit info word the accumulator consumes: SRAM address, accumulate phase and identity select. Drives the `mac_array2psum_acc_*` valid/ready interface. For one output tile it sequences two passes over the same address range:
- pass 0: first input-channel group, buffer write;
- pass 1: second group, read-add-forward.

## Interface
Parameters:
- `DW`, 64, data width of a beat (fixed format: [31:0] psum A, [55:32] psum B, [63:56] identity byte)
- `AW`, 12, psum buffer address width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a tile; ignored while `busy`=1
- `cfg_last_addr`  in  AW  last buffer address of the tile (beats per pass = value+1, range 1..4096); sampled on accepted `start`
- `cfg_identity_en`  in  1  identity select for pass 1; sampled on accepted `start`
- `busy`  out  1  high from accepted `start` until the cycle `done` pulses, inclusive
- `done`  out  1  one-cycle pulse, tile complete
- `mac_data`  in  DW  MAC result beat
- `mac_vld`  in  1  MAC result valid
- `mac_rdy`  out  1  block accepts `mac_data`
- `mac_array2psum_acc_info`  out  32  [11:0] addr, [12] pass (0 = write, 1 = accumulate), [13] identity_sel, [31:14] zero
- `mac_array2psum_acc_data`  out  DW  registered copy of `mac_data`
- `mac_array2psum_acc_vld`  out  1  output valid
- `mac_array2psum_acc_rdy`  in  1  downstream ready

## Operation
- FSM states:
  - IDLE: `start` → PASS0. Latch config; clear addr counter.
  - PASS0: each upstream handshake emits addr = counter, bit12 = 0, bit13 = 0. On the handshake with counter == last_addr: clear counter, go to PASS1 with no idle cycle.
  - PASS1: each upstream handshake emits addr = counter, bit12 = 1, bit13 = latched identity_en. On the handshake with counter == last_addr: go to DRAIN.
  - DRAIN: wait for the output handshake of the final beat, then → DONE.
  - DONE: `done` = 1 for one cycle; → IDLE.
- Single output register stage:
  - `mac_rdy` = (state is PASS0 or PASS1) & (~`mac_array2psum_acc_vld` | `mac_array2psum_acc_rdy`).
  - Upstream handshake = `mac_vld` & `mac_rdy`. It loads data and info into the output register and sets `vld`.
  - Output handshake without a new load clears `vld`.
- Data is passed unmodified; no arithmetic on the data path.
- Counter is AW bits and increments by 1 per upstream handshake. The terminal compare prevents wrap: last_addr = 4095 yields 4096 beats per pass, ending at 0xFFF.
- `mac_rdy` = 0 in IDLE, DRAIN and DONE; MAC beats arriving there are held upstream, not dropped.
- `start` in any non-IDLE state is ignored, and config is not re-sampled.
- Output register contents are stable while `vld` = 1 and `rdy` = 0.

## Timing
- Reset values: `busy` = 0, `done` = 0, `mac_rdy` = 0, `mac_array2psum_acc_vld` = 0, info = 0, data = 0; FSM = IDLE.
- Reset asserted mid-tile: everything returns to reset values immediately. Any partial tile is abandoned, and no `done` is issued.
- `start` at cycle t → `busy` = 1 and `mac_rdy` may be 1 at t+1.
- Latency: upstream handshake at cycle t → beat valid on the output at t+1.
- Throughput: 1 beat/cycle with `rdy` held 1. No bubble at the PASS0→PASS1 boundary.
- Backpressure: `rdy` = 0 with `vld` = 1 forces `mac_rdy` = 0 in the same cycle (combinational path from `rdy`).
- Final pass-1 output handshake at cycle t → DRAIN→DONE, `done` = 1 at t+1, `busy` = 0 at t+2. The earliest next `start` is accepted at t+2.
- Total beats per tile = 2 × (last_addr+1). Pass-1 beat k is always emitted after pass-0 beat k.

## Test plan
1. last_addr = 3, identity_en = 0, `mac_vld` and `rdy` held 1 → 8 output beats on consecutive cycles. Info sequence: 0x000, 0x001, 0x002, 0x003, 0x1000, 0x1001, 0x1002, 0x1003. Data matches input order. Exactly one `done` pulse, one cycle after the last output handshake.
2. last_addr = 1, identity_en = 1 → pass-1 info = 0x3000, 0x3001. Pass-0 info has bit13 = 0.
3. Random `rdy` stalls (50%) and random `mac_vld` gaps over a 64-beat pass → no beat lost or duplicated. Output data/info stay stable during stalls. `mac_rdy` = 0 on every cycle where `vld` & ~`rdy`.
4. last_addr = 4095 → 8192 beats. Pass-0 addresses run 0..0xFFF with no wrap to 0 before the PASS1 transition. Final info = 0x1FFF.
5. `start` pulsed mid-pass-0 with different config → ignored. Sequence and `done` timing are unchanged from the original config.
6. `rst_n` dropped asynchronously during pass 1 → `vld`, `busy`, `mac_rdy` go 0 without a clock edge. After release, a new tile with last_addr = 0 emits exactly info 0x000 then 0x1000 and one `done`.

Source files
------------

// File: rtl/psum_tx.sv
// psum_tx: transmit side of the MAC-array -> psum-accumulator link.
//
// Takes raw MAC result beats and tags each one with the info word that
// the accumulator consumes. For one output tile the block makes two passes
// over the same buffer address range:
//   pass 0: first input-channel group, buffer write       (info[12] = 0)
//   pass 1: second input-channel group, read-add-forward  (info[12] = 1)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle pulse that begins a tile (ignored while busy)
//   cfg_last_addr              last buffer address of the tile (beats per pass = value+1)
//   cfg_identity_en            identity select applied to pass-1 beats
//   busy                       high from the accepted start through the done cycle
//   done                       one-cycle pulse when the tile is complete
//   mac_data/mac_vld/mac_rdy   upstream beat interface
//   mac_array2psum_acc_info    [11:0] addr, [12] pass, [13] identity_sel, [31:14] zero
//   mac_array2psum_acc_data    registered copy of mac_data
//   mac_array2psum_acc_vld/rdy downstream handshake
//
// Handshake rule (both sides): a beat transfers on a rising clk edge where
// vld and rdy are both 1. A producer holding vld=1 keeps its payload stable
// until that transfer. mac_rdy depends combinationally on
// mac_array2psum_acc_rdy, so the single output register sustains one beat
// per cycle.
//
// The FSM state is kept in the named signal `state` (type state_t) so that
// checkers can bind to it directly.

module psum_tx #(
  parameter int DW = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] cfg_last_addr,
  input  logic          cfg_identity_en,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] mac_data,
  input  logic          mac_vld,
  output logic          mac_rdy,
  output logic [31:0]   mac_array2psum_acc_info,
  output logic [DW-1:0] mac_array2psum_acc_data,
  output logic          mac_array2psum_acc_vld,
  input  logic          mac_array2psum_acc_rdy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS0 = 3'd1,
    PASS1 = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] last_addr;
  logic          identity_en;
  logic          in_pass;
  logic          up_hs;
  logic          out_hs;
  logic          cnt_last;
  logic [31:0]   info_nxt;

  assign in_pass  = (state == PASS0) || (state == PASS1);
  assign mac_rdy  = in_pass && (!mac_array2psum_acc_vld || mac_array2psum_acc_rdy);
  assign up_hs    = mac_vld && mac_rdy;
  assign out_hs   = mac_array2psum_acc_vld && mac_array2psum_acc_rdy;
  // The terminal compare (not a carry-out) ends each pass, so a full
  // 4096-beat pass finishes at 0xFFF without wrapping.
  assign cnt_last = (cnt == last_addr);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PASS0;
      PASS0:   if (up_hs && cnt_last) state_nxt = PASS1;
      PASS1:   if (up_hs && cnt_last) state_nxt = DRAIN;
      // On entry to DRAIN the final pass-1 beat sits in the output register.
      DRAIN:   if (out_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------- config and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_addr   <= '0;
      identity_en <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt         <= '0;
      last_addr   <= cfg_last_addr;
      identity_en <= cfg_identity_en;
    end else if (up_hs) begin
      // Wrap to 0 at the end of a pass; after pass 1 the value is unused.
      cnt <= cnt_last ? '0 : cnt + AW'(1);
    end
  end

  // Info word for the beat being accepted this cycle.
  always_comb begin
    info_nxt         = '0;
    info_nxt[AW-1:0] = cnt;
    info_nxt[12]     = (state == PASS1);
    info_nxt[13]     = (state == PASS1) && identity_en;
  end

  // -------------------------------------------------- output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_array2psum_acc_vld  <= 1'b0;
      mac_array2psum_acc_info <= '0;
      mac_array2psum_acc_data <= '0;
    end else if (up_hs) begin
      mac_array2psum_acc_vld  <= 1'b1;
      mac_array2psum_acc_info <= info_nxt;
      mac_array2psum_acc_data <= mac_data;
    end else if (mac_array2psum_acc_rdy) begin
      mac_array2psum_acc_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_tx.sv
// Testbench for psum_tx: randomized upstream/downstream handshakes checked
// against a per-tile scoreboard whose expected beats are computed from the
// tile rules (pass 0 addresses 0..last, then pass 1 with the pass and
// identity bits set, data in input order).

module tb_psum_tx;

  localparam int DW = 64;
  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_last_addr;
  logic          cfg_identity_en;
  logic          busy;
  logic          done;
  logic [DW-1:0] mac_data;
  logic          mac_vld;
  logic          mac_rdy;
  logic [31:0]   acc_info;
  logic [DW-1:0] acc_data;
  logic          acc_vld;
  logic          acc_rdy;

  int n_checks = 0;
  int n_errors = 0;

  psum_tx #(.DW(DW), .AW(AW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start                   (start),
    .cfg_last_addr           (cfg_last_addr),
    .cfg_identity_en         (cfg_identity_en),
    .busy                    (busy),
    .done                    (done),
    .mac_data                (mac_data),
    .mac_vld                 (mac_vld),
    .mac_rdy                 (mac_rdy),
    .mac_array2psum_acc_info (acc_info),
    .mac_array2psum_acc_data (acc_data),
    .mac_array2psum_acc_vld  (acc_vld),
    .mac_array2psum_acc_rdy  (acc_rdy)
  );

  // ---------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------- checking
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------- driver + scoreboard
  // Runs one tile. Inputs change just after the falling edge; outputs and
  // handshakes are sampled 1 ns later, so the handshake decisions recorded
  // here are exactly the transfers that happen at the next rising edge.
  // abort_at > 0 returns as soon as that many output beats have been seen.
  task automatic run_tile(input int last, input bit id, input int vld_pct,
                          input int rdy_pct, input bit inject, input int abort_at,
                          input bit full_rate);
    logic [63:0] exp_q[$];
    logic [31:0] exp_info_q[$];
    logic [63:0] src[$];
    int          beats;
    int          total;
    int          in_idx;
    int          out_idx;
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          first_hs;
    int          last_hs;
    int          limit;
    bit          hold;
    logic [31:0] h_info;
    logic [63:0] h_data;

    beats = last + 1;
    total = 2 * beats;
    for (int n = 0; n < total; n++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      src.push_back(d);
      exp_q.push_back(d);
      if (n < beats) exp_info_q.push_back(32'(n));
      else           exp_info_q.push_back(32'h1000 | (id ? 32'h2000 : 32'h0) | 32'(n - beats));
    end

    in_idx = 0; out_idx = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
    first_hs = -1; last_hs = -10; hold = 1'b0; h_info = '0; h_data = '0;
    limit = 20 * total + 50;

    forever begin
      @(negedge clk);
      start = (cyc == 0) || (inject && cyc == 3);
      if (cyc == 0) begin
        cfg_last_addr   = AW'(last);
        cfg_identity_en = id;
      end else begin
        // Anything other than the accepted config; must be ignored.
        cfg_last_addr   = AW'(last + 1 + $urandom_range(100));
        cfg_identity_en = ~id;
      end
      mac_vld  = (in_idx < total) && ($urandom_range(99) < vld_pct);
      mac_data = (in_idx < total) ? src[in_idx] : {$urandom, $urandom};
      acc_rdy  = ($urandom_range(99) < rdy_pct);
      #1;

      if (cyc == 0) check_eq("busy_idle", 64'(busy), 64'd0);
      if (cyc == 1) check_eq("busy_after_start", 64'(busy), 64'd1);

      if (hold) begin
        check_eq("stall_vld", 64'(acc_vld), 64'd1);
        check_eq("stall_info", 64'(acc_info), 64'(h_info));
        check_eq("stall_data", acc_data, h_data);
      end
      if (acc_vld && !acc_rdy) check_eq("bp_mac_rdy", 64'(mac_rdy), 64'd0);
      hold   = acc_vld && !acc_rdy;
      h_info = acc_info;
      h_data = acc_data;

      if (mac_vld && mac_rdy) in_idx++;

      if (acc_vld && acc_rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 64'(out_idx), 64'(total - 1));
        end else begin
          check_eq("out_info", 64'(acc_info), 64'(exp_info_q.pop_front()));
          check_eq("out_data", acc_data, exp_q.pop_front());
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        out_idx++;
        if (abort_at > 0 && out_idx == abort_at) return;
      end

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_latency", 64'(cyc), 64'(last_hs + 1));
      end

      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check_eq("busy_after_done", 64'(busy), 64'd0);
        check_eq("done_width", 64'(done), 64'd0);
        check_eq("beat_count", 64'(out_idx), 64'(total));
        check_eq("done_count", 64'(done_cnt), 64'd1);
        if (full_rate) check_eq("throughput", 64'(last_hs - first_hs), 64'(total - 1));
        break;
      end

      cyc++;
      if (cyc > limit) begin
        check_eq("tile_timeout", 64'(cyc), 64'(limit));
        break;
      end
    end
    start   = 1'b0;
    mac_vld = 1'b0;
  endtask

  // ---------------------------------------------------- main sequence
  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_last_addr = '0; cfg_identity_en = 1'b0;
    mac_data = '0; mac_vld = 1'b0; acc_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_mac_rdy", 64'(mac_rdy), 64'd0);
    check_eq("rst_vld", 64'(acc_vld), 64'd0);
    check_eq("rst_info", 64'(acc_info), 64'd0);
    check_eq("rst_data", acc_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-rate small tile, then identity select on pass 1.
    run_tile(3, 1'b0, 100, 100, 1'b0, 0, 1'b1);
    run_tile(1, 1'b1, 100, 100, 1'b0, 0, 1'b1);

    // Random stalls on both sides over 64-beat passes.
    run_tile(63, 1'b1, 70, 50, 1'b0, 0, 1'b0);
    run_tile(63, 1'b0, 40, 50, 1'b0, 0, 1'b0);

    // Maximum tile: 4096 beats per pass, no wrap before pass 1.
    run_tile(4095, 1'b0, 100, 100, 1'b0, 0, 1'b1);

    // start pulsed mid-pass-0 with a different config must be ignored.
    run_tile(5, 1'b0, 100, 100, 1'b1, 0, 1'b1);
    run_tile(7, 1'b1, 80, 60, 1'b1, 0, 1'b0);

    // Asynchronous reset in the middle of pass 1.
    run_tile(7, 1'b0, 100, 100, 1'b0, 10, 1'b0);
    @(posedge clk);
    #2;
    check_eq("pre_rst_mac_rdy", 64'(mac_rdy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_vld", 64'(acc_vld), 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_mac_rdy", 64'(mac_rdy), 64'd0);
    check_eq("async_rst_info", 64'(acc_info), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("post_rst_no_done", 64'(done), 64'd0);
      check_eq("post_rst_idle", 64'(busy), 64'd0);
    end
    run_tile(0, 1'b0, 100, 100, 1'b0, 0, 1'b1);
    run_tile(0, 1'b1, 50, 50, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
